// File: rtl/add_seq_nib_pkg.sv
// Shared constants for the nibble-serial adder/subtractor.
// State encoding and the width of the single nibble adder.
package add_seq_nib_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/add_seq_nib_rca.sv
// rca_4b: 4-bit ripple-carry nibble adder.
// Pure combinational; one instance serves every nibble of the word.
module rca_4b
    import add_seq_nib_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic c1;
    logic c2;
    logic c3;

    assign s[0] = a[0] ^ b[0] ^ ci;
    assign c1   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
    assign s[1] = a[1] ^ b[1] ^ c1;
    assign c2   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    assign s[2] = a[2] ^ b[2] ^ c2;
    assign c3   = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
    assign s[3] = a[3] ^ b[3] ^ c3;
    assign co   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/add_seq_nib.sv
// Multi-cycle N-bit adder/subtractor, one nibble per clock, LSB first.
// valid/ready on both sides; carry is registered between nibbles.
module add_seq_nib
    import add_seq_nib_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int NIB   = N / NIB_W;
    localparam int CNT_W = $clog2(NIB);

    if ((N % NIB_W) != 0 || N < 8) begin : g_bad_n
        $error("add_seq_nib: N must be a multiple of 4 and >= 8");
    end

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [N-1:0]       a_q;
    logic [N-1:0]       b_q;
    logic [N-1:0]       sum_q;
    logic               carry_q;
    logic               c_out_q;
    logic               ovf_q;
    logic               last;
    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic [NIB_W-1:0]   nib_s;
    logic               nib_co;

    assign last  = (cnt_q == CNT_W'(NIB - 1));
    assign nib_a = a_q[cnt_q*NIB_W +: NIB_W];
    assign nib_b = b_q[cnt_q*NIB_W +: NIB_W];

    rca_4b u_rca (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | c_in;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    sum_q[cnt_q*NIB_W +: NIB_W] <= nib_s;
                    carry_q <= nib_co;
                    cnt_q   <= cnt_q + 1'b1;
                    // nib_s[3] is the new sum MSB on the final nibble
                    if (last) begin
                        c_out_q <= nib_co;
                        ovf_q   <= (a_q[N-1] == b_q[N-1]) &&
                                   (nib_s[NIB_W-1] != a_q[N-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_add_seq_nib.sv
// Self-checking bench for add_seq_nib (N=16).
// Vector table plus hand sequences, with an expected-result queue.
module tb_add_seq_nib;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        c_in;
        logic [15:0] e_sum;
        logic        e_c;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    add_seq_nib #(.N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input vec_t v);
        logic [16:0] r;
        logic [15:0] bb;
        exp_t e;
        bb  = v.sub ? ~v.b : v.b;
        r   = {1'b0, v.a} + {1'b0, bb} + {16'd0, (v.sub | v.c_in)};
        e.s = r[15:0];
        e.c = r[16];
        e.v = (v.a[15] == bb[15]) && (r[15] != v.a[15]);
        return e;
    endfunction

    // Accept one op, wait for result, hold off out_ready for 'hold' cycles.
    task automatic run_op(input vec_t v, input int hold, input string nm);
        int   lat;
        exp_t e;
        logic [15:0] s0;
        @(negedge clk);
        chk({nm, " in_ready_idle"}, in_ready, 1);
        a = v.a; b = v.b; sub = v.sub; c_in = v.c_in;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        sb.push_back('{s: v.e_sum, c: v.e_c, v: v.e_ovf});
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 20);
        chk({nm, " latency"}, lat, 4);
        if (sb.size() == 0) begin
            chk({nm, " sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({nm, " sum"}, sum, e.s);
        chk({nm, " c_out"}, c_out, e.c);
        chk({nm, " ovf"}, ovf, e.v);
        s0 = sum;
        for (int i = 0; i < hold; i++) begin
            a = 16'hAAAA; b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk({nm, " hold_valid"}, out_valid, 1);
            chk({nm, " hold_in_ready"}, in_ready, 0);
            chk({nm, " hold_sum"}, sum, s0);
            chk({nm, " hold_ovf"}, ovf, e.v);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({nm, " drop_valid"}, out_valid, 0);
        chk({nm, " kept_sum"}, sum, s0);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[3] = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b1, 16'h0E1E, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
        #12;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst sum", sum, 0);
        chk("rst c_out", c_out, 0);
        chk("rst ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_op(tbl[i], 0, $sformatf("vec%0d", i));

        run_op('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
               5, "bp");
        @(negedge clk);
        chk("bp idle_ready", in_ready, 1);
        chk("bp no_ghost", out_valid, 0);

        for (int i = 0; i < 8; i++) begin
            vec_t v;
            exp_t e;
            v.a = 16'($urandom); v.b = 16'($urandom);
            v.sub = 1'($urandom); v.c_in = 1'($urandom);
            e = model(v);
            v.e_sum = e.s; v.e_c = e.c; v.e_ovf = e.v;
            run_op(v, i % 3, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of an operation
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; c_in = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst in_ready", in_ready, 1);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst sum", sum, 0);
        chk("midrst c_out", c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("midrst no_result", seen, 0);
        end
        out_ready = 1'b0;

        run_op(tbl[0], 1, "post_rst");
        chk("sb drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
